memory: RTL and testbench
=========================

MEMORY -- requirements
Module: memory

Interface
REQ-001 SHALL expose parameter DEPTH, default 64, data-memory word count (power of two).
REQ-002 SHALL expose ports exactly as follows (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Ctl_MemtoReg_in  in  1  WB select, forwarded.
- Ctl_RegWrite_in  in  1  WB register-write enable, forwarded.
- Ctl_MemRead_in  in  1  load enable.
- Ctl_MemWrite_in  in  1  store enable.
- Ctl_Branch_in  in  1  branch instruction flag.
- Zero_in  in  1  ALU zero flag.
- Rd_in  in  5  destination register index.
- Write_Data  in  32  store data.
- ALUresult_in  in  32  memory word address / ALU result.
- PCimm_in  in  32  branch target.
- Ctl_MemtoReg_out  out  1  registered copy.
- Ctl_RegWrite_out  out  1  registered copy.
- Rd_out  out  5  registered copy.
- Read_Data  out  32  registered load data.
- ALUresult_out  out  32  registered copy.
- PCimm_out  out  32  branch target to fetch.
- PCSrc  out  1  branch-taken select.
REQ-003 SHALL use one clock domain (clk) with synchronous, active-high reset named reset.

Function
REQ-004 Data memory SHALL be DEPTH x 32-bit words, indexed by ALUresult_in[log2(DEPTH)-1:0] as a word index; upper bits ignored (wrap-around).
REQ-005 Store: on rising clk with Ctl_MemWrite_in=1 and reset=0, mem[index] SHALL take Write_Data (full word).
REQ-006 Load: on rising clk with Ctl_MemRead_in=1, Read_Data SHALL take mem[index]; with Ctl_MemRead_in=0 it SHALL take 0.
REQ-007 Simultaneous read and write to the same index SHALL return the old contents (read-before-write); the new value is visible on the next read.
REQ-008 Ctl_MemtoReg_out, Ctl_RegWrite_out, Rd_out, ALUresult_out SHALL register their inputs every rising clk (1-cycle latency, no enable/stall).
REQ-009 PCSrc SHALL be combinational: Ctl_Branch_in AND Zero_in.
REQ-010 PCimm_out SHALL be a combinational pass-through of PCimm_in.
REQ-011 Read_Data and the MEM/WB copies of one instruction SHALL appear on the same clock edge.

Reset
REQ-012 While reset=1 at a rising edge, all registered outputs SHALL become 0 and every memory word SHALL be cleared to 0.
REQ-013 Stores asserted during reset SHALL be ignored; reset mid-operation discards in-flight data.
REQ-014 PCSrc and PCimm_out SHALL remain combinational during reset.

Structure
REQ-015 Shared package SHALL hold DATA_W=32, REG_IDX_W=5, DEPTH default 64.
REQ-016 Memory array SHALL live in one sub-module data_mem (sync write, sync read, sync clear); pipeline register and branch logic in the top.

Verification
REQ-017 Reset 2 cycles, then idle -> all registered outputs 0, PCSrc 0.
REQ-018 Store 4@17, 5@12, 6@7 on successive cycles, then load 17, 12, 7 -> Read_Data 4, 5, 6 one cycle after each load.
REQ-019 Branch=1, Zero=0, PCimm_in=32 -> PCSrc 0, PCimm_out 32; then Zero=1, PCimm_in=44 -> PCSrc 1, PCimm_out 44 same cycle.
REQ-020 Load and store index 12 with Write_Data=9 where mem[12]=5 -> Read_Data 5; next-cycle load -> 9.
REQ-021 Store 7@(DEPTH+3), load 3 -> Read_Data 7 (wrap).
REQ-022 Rd_in=5'd31, RegWrite=1, MemtoReg=1, ALUresult_in=0xDEADBEEF -> same values on outputs one edge later; reset asserted -> 0 next edge.

Source files
------------

// File: rtl/memory_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// memory_pkg: shared widths and the MEM/WB pipeline record.
// Revision: 1.0
// ------------------------------------------------------------------
package memory_pkg;

  localparam int DATA_W        = 32;
  localparam int REG_IDX_W     = 5;
  localparam int DEFAULT_DEPTH = 64;

  typedef struct packed {
    logic                 memtoreg;
    logic                 regwrite;
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    alu;
  } memwb_t;

endpackage
`default_nettype wire

// File: rtl/memory_if.sv
`default_nettype none
// ------------------------------------------------------------------
// memory_if: bundle of the MEM-stage bus seen by the memory block.
// Revision: 1.0
// ------------------------------------------------------------------
interface memory_if;
  import memory_pkg::*;

  logic                 Ctl_MemtoReg_in;
  logic                 Ctl_RegWrite_in;
  logic                 Ctl_MemRead_in;
  logic                 Ctl_MemWrite_in;
  logic                 Ctl_Branch_in;
  logic                 Zero_in;
  logic [REG_IDX_W-1:0] Rd_in;
  logic [DATA_W-1:0]    Write_Data;
  logic [DATA_W-1:0]    ALUresult_in;
  logic [DATA_W-1:0]    PCimm_in;
  logic                 Ctl_MemtoReg_out;
  logic                 Ctl_RegWrite_out;
  logic [REG_IDX_W-1:0] Rd_out;
  logic [DATA_W-1:0]    Read_Data;
  logic [DATA_W-1:0]    ALUresult_out;
  logic [DATA_W-1:0]    PCimm_out;
  logic                 PCSrc;

  modport master (
    output Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in,
           Ctl_Branch_in, Zero_in, Rd_in, Write_Data, ALUresult_in, PCimm_in,
    input  Ctl_MemtoReg_out, Ctl_RegWrite_out, Rd_out, Read_Data,
           ALUresult_out, PCimm_out, PCSrc
  );

  modport slave (
    input  Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in,
           Ctl_Branch_in, Zero_in, Rd_in, Write_Data, ALUresult_in, PCimm_in,
    output Ctl_MemtoReg_out, Ctl_RegWrite_out, Rd_out, Read_Data,
           ALUresult_out, PCimm_out, PCSrc
  );

endinterface
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// ------------------------------------------------------------------
// data_mem: DEPTH x DATA_W word memory, sync write/read/clear.
// Revision: 1.0
// ------------------------------------------------------------------
module data_mem
  import memory_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  input  wire logic [$clog2(DEPTH)-1:0] addr_i,
  input  wire logic                     wr_en_i,
  input  wire logic                     rd_en_i,
  input  wire logic [DATA_W-1:0]        wdata_i,
  output logic      [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read samples the array before this edge's write lands: read-before-write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      rdata_q <= rd_en_i ? mem_q[addr_i] : '0;
      if (wr_en_i) begin
        mem_q[addr_i] <= wdata_i;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/memory.sv
`default_nettype none
// ------------------------------------------------------------------
// memory: MEM pipeline stage - data memory, MEM/WB register, branch select.
// Revision: 1.0
// ------------------------------------------------------------------
module memory
  import memory_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 Ctl_MemtoReg_in,
  input  wire logic                 Ctl_RegWrite_in,
  input  wire logic                 Ctl_MemRead_in,
  input  wire logic                 Ctl_MemWrite_in,
  input  wire logic                 Ctl_Branch_in,
  input  wire logic                 Zero_in,
  input  wire logic [REG_IDX_W-1:0] Rd_in,
  input  wire logic [DATA_W-1:0]    Write_Data,
  input  wire logic [DATA_W-1:0]    ALUresult_in,
  input  wire logic [DATA_W-1:0]    PCimm_in,
  output logic                      Ctl_MemtoReg_out,
  output logic                      Ctl_RegWrite_out,
  output logic      [REG_IDX_W-1:0] Rd_out,
  output logic      [DATA_W-1:0]    Read_Data,
  output logic      [DATA_W-1:0]    ALUresult_out,
  output logic      [DATA_W-1:0]    PCimm_out,
  output logic                      PCSrc
);

  localparam int ADDR_W = $clog2(DEPTH);

  memwb_t memwb_d;
  memwb_t memwb_q;

  // Upper address bits are dropped so accesses wrap around the array.
  data_mem #(
    .DEPTH (DEPTH)
  ) u_data_mem (
    .clk     (clk),
    .reset   (reset),
    .addr_i  (ALUresult_in[ADDR_W-1:0]),
    .wr_en_i (Ctl_MemWrite_in),
    .rd_en_i (Ctl_MemRead_in),
    .wdata_i (Write_Data),
    .rdata_o (Read_Data)
  );

  always_comb begin
    memwb_d          = '0;
    memwb_d.memtoreg = Ctl_MemtoReg_in;
    memwb_d.regwrite = Ctl_RegWrite_in;
    memwb_d.rd       = Rd_in;
    memwb_d.alu      = ALUresult_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      memwb_q <= '0;
    end else begin
      memwb_q <= memwb_d;
    end
  end

  assign Ctl_MemtoReg_out = memwb_q.memtoreg;
  assign Ctl_RegWrite_out = memwb_q.regwrite;
  assign Rd_out           = memwb_q.rd;
  assign ALUresult_out    = memwb_q.alu;

  assign PCSrc     = Ctl_Branch_in & Zero_in;
  assign PCimm_out = PCimm_in;

endmodule
`default_nettype wire

// File: tb/tb_memory.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_memory: random + directed stimulus against a word-array model.
// Revision: 1.0
// ------------------------------------------------------------------
module tb_memory;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  memory_if bus();

  always #5 clk = ~clk;

  memory #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .Ctl_MemtoReg_in  (bus.Ctl_MemtoReg_in),
    .Ctl_RegWrite_in  (bus.Ctl_RegWrite_in),
    .Ctl_MemRead_in   (bus.Ctl_MemRead_in),
    .Ctl_MemWrite_in  (bus.Ctl_MemWrite_in),
    .Ctl_Branch_in    (bus.Ctl_Branch_in),
    .Zero_in          (bus.Zero_in),
    .Rd_in            (bus.Rd_in),
    .Write_Data       (bus.Write_Data),
    .ALUresult_in     (bus.ALUresult_in),
    .PCimm_in         (bus.PCimm_in),
    .Ctl_MemtoReg_out (bus.Ctl_MemtoReg_out),
    .Ctl_RegWrite_out (bus.Ctl_RegWrite_out),
    .Rd_out           (bus.Rd_out),
    .Read_Data        (bus.Read_Data),
    .ALUresult_out    (bus.ALUresult_out),
    .PCimm_out        (bus.PCimm_out),
    .PCSrc            (bus.PCSrc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain word array plus the values each output must hold.
  logic [31:0] mm [DEPTH];
  logic [31:0] e_rdata, e_alu;
  logic [4:0]  e_rd;
  logic        e_m2r, e_rw;
  int          idx;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mm[i] = '0;
      e_rdata = '0; e_alu = '0; e_rd = '0; e_m2r = 1'b0; e_rw = 1'b0;
    end else begin
      idx     = int'(bus.ALUresult_in % DEPTH);
      e_rdata = bus.Ctl_MemRead_in ? mm[idx] : 32'd0;
      if (bus.Ctl_MemWrite_in) mm[idx] = bus.Write_Data;
      e_alu = bus.ALUresult_in;
      e_rd  = bus.Rd_in;
      e_m2r = bus.Ctl_MemtoReg_in;
      e_rw  = bus.Ctl_RegWrite_in;
    end
    #1;
    chk("m.Read_Data",     bus.Read_Data,               e_rdata);
    chk("m.ALUresult_out", bus.ALUresult_out,           e_alu);
    chk("m.Rd_out",        {27'd0, bus.Rd_out},         {27'd0, e_rd});
    chk("m.MemtoReg_out",  {31'd0, bus.Ctl_MemtoReg_out}, {31'd0, e_m2r});
    chk("m.RegWrite_out",  {31'd0, bus.Ctl_RegWrite_out}, {31'd0, e_rw});
    chk("m.PCSrc",         {31'd0, bus.PCSrc},
        {31'd0, bus.Ctl_Branch_in && bus.Zero_in});
    chk("m.PCimm_out",     bus.PCimm_out,               bus.PCimm_in);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.Ctl_MemtoReg_in = 1'b0; bus.Ctl_RegWrite_in = 1'b0;
    bus.Ctl_MemRead_in  = 1'b0; bus.Ctl_MemWrite_in = 1'b0;
    bus.Ctl_Branch_in   = 1'b0; bus.Zero_in         = 1'b0;
    bus.Rd_in = '0; bus.Write_Data = '0; bus.ALUresult_in = '0; bus.PCimm_in = '0;
  endtask

  logic [31:0] r;

  initial begin
    reset = 1'b1;
    idle();
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst.Read_Data", bus.Read_Data,     32'd0);
    chk("rst.ALUresult", bus.ALUresult_out, 32'd0);
    chk("rst.Rd_out",    {27'd0, bus.Rd_out}, 32'd0);
    chk("rst.PCSrc",     {31'd0, bus.PCSrc},  32'd0);

    bus.Ctl_MemWrite_in = 1'b1;
    bus.ALUresult_in = 32'd17; bus.Write_Data = 32'd4; tick();
    bus.ALUresult_in = 32'd12; bus.Write_Data = 32'd5; tick();
    bus.ALUresult_in = 32'd7;  bus.Write_Data = 32'd6; tick();
    bus.Ctl_MemWrite_in = 1'b0; bus.Ctl_MemRead_in = 1'b1;
    bus.ALUresult_in = 32'd17; tick(); chk("ld17", bus.Read_Data, 32'd4);
    bus.ALUresult_in = 32'd12; tick(); chk("ld12", bus.Read_Data, 32'd5);
    bus.ALUresult_in = 32'd7;  tick(); chk("ld7",  bus.Read_Data, 32'd6);

    bus.Ctl_MemRead_in = 1'b0;
    bus.Ctl_Branch_in = 1'b1; bus.Zero_in = 1'b0; bus.PCimm_in = 32'd32; #1;
    chk("br.nt.PCSrc", {31'd0, bus.PCSrc}, 32'd0);
    chk("br.nt.PCimm", bus.PCimm_out, 32'd32);
    bus.Zero_in = 1'b1; bus.PCimm_in = 32'd44; #1;
    chk("br.t.PCSrc", {31'd0, bus.PCSrc}, 32'd1);
    chk("br.t.PCimm", bus.PCimm_out, 32'd44);
    bus.Ctl_Branch_in = 1'b0; bus.Zero_in = 1'b0;
    tick();

    bus.Ctl_MemRead_in = 1'b1; bus.Ctl_MemWrite_in = 1'b1;
    bus.ALUresult_in = 32'd12; bus.Write_Data = 32'd9; tick();
    chk("rbw.old", bus.Read_Data, 32'd5);
    bus.Ctl_MemWrite_in = 1'b0; tick();
    chk("rbw.new", bus.Read_Data, 32'd9);

    bus.Ctl_MemRead_in = 1'b0; bus.Ctl_MemWrite_in = 1'b1;
    bus.ALUresult_in = DEPTH + 3; bus.Write_Data = 32'd7; tick();
    bus.Ctl_MemWrite_in = 1'b0; bus.Ctl_MemRead_in = 1'b1;
    bus.ALUresult_in = 32'd3; tick();
    chk("wrap", bus.Read_Data, 32'd7);

    bus.Ctl_MemRead_in = 1'b0;
    bus.Rd_in = 5'd31; bus.Ctl_RegWrite_in = 1'b1; bus.Ctl_MemtoReg_in = 1'b1;
    bus.ALUresult_in = 32'hDEADBEEF; tick();
    chk("wb.Rd",       {27'd0, bus.Rd_out},              32'd31);
    chk("wb.RegWrite", {31'd0, bus.Ctl_RegWrite_out},    32'd1);
    chk("wb.MemtoReg", {31'd0, bus.Ctl_MemtoReg_out},    32'd1);
    chk("wb.ALU",      bus.ALUresult_out,                32'hDEADBEEF);
    reset = 1'b1; tick();
    chk("wbrst.Rd",  {27'd0, bus.Rd_out},           32'd0);
    chk("wbrst.RW",  {31'd0, bus.Ctl_RegWrite_out}, 32'd0);
    chk("wbrst.ALU", bus.ALUresult_out,             32'd0);
    reset = 1'b0; idle();
    bus.Ctl_MemRead_in = 1'b1; bus.ALUresult_in = 32'd17; tick();
    chk("clr.ld17", bus.Read_Data, 32'd0);

    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      bus.Ctl_MemtoReg_in = 1'($urandom);
      bus.Ctl_RegWrite_in = 1'($urandom);
      bus.Ctl_MemRead_in  = 1'($urandom);
      bus.Ctl_MemWrite_in = 1'($urandom);
      bus.Ctl_Branch_in   = 1'($urandom);
      bus.Zero_in         = 1'($urandom);
      bus.Rd_in           = 5'($urandom);
      bus.Write_Data      = $urandom;
      bus.PCimm_in        = $urandom;
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[5:0] = 6'($urandom_range(0, 7));
      bus.ALUresult_in = r;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
